signed_product_accumulator: RTL and testbench

- Sequential accumulation stage directly downstream of the 4x4 signed Baugh-Wooley multiplier.
- Consumes the multiplier's 8-bit two's-complement products over a valid/ready handshake and sums exactly LEN of them into a saturating signed accumulator, i.e. one dot-product term set.
- Presents the result over a second valid/ready handshake to the next consumer.
- Overflow is reported as a sticky flag.

---
 rtl/signed_product_accumulator.sv | 141 ++++++++++++++
 tb/tb_signed_product_accumulator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/signed_product_accumulator.sv
// Saturating signed dot-product accumulator: sums LEN products from the multiplier
// over a valid/ready handshake and holds the result until the consumer takes it.
module signed_product_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 10,
  parameter int unsigned LEN    = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned EXT_W = SUM_W - PROD_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               prod_ready_q, prod_ready_d;
  logic               acc_valid_q, acc_valid_d;
  logic               busy_q, busy_d;

  logic [SUM_W-1:0]   acc_ext;
  logic [SUM_W-1:0]   prod_ext;
  logic [SUM_W-1:0]   sum;
  logic               sum_hi;
  logic               sum_lo;
  logic [ACC_W-1:0]   sat_sum;
  logic               accept;

  // One extra bit of headroom: the top two bits disagree exactly when the sum left the rail range.
  always_comb begin
    acc_ext  = {acc_q[ACC_W-1], acc_q};
    prod_ext = {{EXT_W{prod_in[PROD_W-1]}}, prod_in};
    sum      = acc_ext + prod_ext;
    sum_hi   = (sum[SUM_W-1] == 1'b0) && (sum[ACC_W-1] == 1'b1);
    sum_lo   = (sum[SUM_W-1] == 1'b1) && (sum[ACC_W-1] == 1'b0);
    if (sum_hi) begin
      sat_sum = ACC_MAX;
    end else if (sum_lo) begin
      sat_sum = ACC_MIN;
    end else begin
      sat_sum = sum[ACC_W-1:0];
    end
  end

  assign accept = prod_valid && prod_ready_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    prod_ready_d = 1'b0;
    acc_valid_d  = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d   = sat_sum;
          count_d = count_q + CNT_W'(1);
          if (sum_hi || sum_lo) begin
            ovf_d = 1'b1;
          end
          if (count_q == LAST_CNT) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (acc_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake flags follow the upcoming state so they are flop outputs.
    prod_ready_d = (state_d == ST_ACCUM);
    acc_valid_d  = (state_d == ST_HOLD);
    busy_d       = (state_d == ST_ACCUM) || (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      acc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      prod_ready_q <= prod_ready_d;
      acc_valid_q  <= acc_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign prod_ready = prod_ready_q;
  assign acc_out    = acc_q;
  assign acc_valid  = acc_valid_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_signed_product_accumulator.sv
// Randomized and directed bench for signed_product_accumulator against a plain-arithmetic model.
module tb_signed_product_accumulator;

  localparam int unsigned PROD_W = 8;
  localparam int unsigned ACC_W  = 10;
  localparam int unsigned LEN    = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int          RAIL_MAX = 511;
  localparam int          RAIL_MIN = -512;

  logic              clk;
  logic              rst;
  logic              start;
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready;
  logic              overflow;
  logic              busy;

  int n_cmp;
  int n_err;

  signed_product_accumulator #(
    .PROD_W(PROD_W), .ACC_W(ACC_W), .LEN(LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .prod_in(prod_in),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint acc_s();
    return longint'($signed(acc_out));
  endfunction

  // Reference: clamp after every addition, flag any clamp.
  function automatic int model_sum(input int q[$], output bit ovf);
    int s;
    s = 0;
    ovf = 1'b0;
    foreach (q[i]) begin
      s = s + q[i];
      if (s > RAIL_MAX) begin s = RAIL_MAX; ovf = 1'b1; end
      if (s < RAIL_MIN) begin s = RAIL_MIN; ovf = 1'b1; end
    end
    return s;
  endfunction

  // All tasks begin and end just after a falling edge.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag, input longint exp_acc);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_prod_ready"}, prod_ready, 0);
    check_eq({tag, "_acc_valid"}, acc_valid, 0);
    check_eq({tag, "_acc_out"}, acc_s(), exp_acc);
  endtask

  // Start, feed products with random gaps, hold with start pulses, then release.
  task automatic run_dot(input string tag, input int q[$], input int gap_max, input int hold_cycles);
    int  exp;
    bit  exp_ovf;
    int  gap;
    exp = model_sum(q, exp_ovf);

    start = 1'b1; prod_valid = 1'b1; prod_in = 8'h55;
    @(negedge clk);
    start = 1'b0; prod_valid = 1'b0;
    check_eq({tag, "_start_busy"}, busy, 1);
    check_eq({tag, "_start_ready"}, prod_ready, 1);
    check_eq({tag, "_start_acc"}, acc_s(), 0);
    check_eq({tag, "_start_ovf"}, overflow, 0);

    foreach (q[i]) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max)) : 0;
      repeat (gap) begin
        prod_valid = 1'b0; prod_in = 8'(int'($urandom));
        @(negedge clk);
      end
      check_eq({tag, "_acc_valid_early"}, acc_valid, 0);
      check_eq({tag, "_ready_in_accum"}, prod_ready, 1);
      prod_valid = 1'b1; prod_in = 8'(q[i]);
      @(negedge clk);
      prod_valid = 1'b0;
    end

    check_eq({tag, "_acc_valid_lat1"}, acc_valid, 1);
    check_eq({tag, "_result"}, acc_s(), exp);
    check_eq({tag, "_ovf"}, overflow, exp_ovf);
    check_eq({tag, "_hold_ready"}, prod_ready, 0);

    acc_ready = 1'b0;
    for (int h = 0; h < hold_cycles; h++) begin
      start = (h % 2 == 0); prod_valid = 1'b1;
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, acc_valid, 1);
      check_eq({tag, "_hold_acc"}, acc_s(), exp);
      check_eq({tag, "_hold_busy"}, busy, 1);
    end
    start = 1'b1; acc_ready = 1'b1; prod_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; acc_ready = 1'b0;
    check_idle({tag, "_release"}, exp);
    check_eq({tag, "_release_ovf"}, overflow, exp_ovf);
    @(negedge clk);
    check_eq({tag, "_stay_idle"}, busy, 0);
  endtask

  initial begin
    int q[$];
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; prod_in = '0; prod_valid = 1'b0; acc_ready = 1'b0;
    @(negedge clk);

    // Reset and idle behaviour.
    do_reset(2);
    check_idle("reset", 0);
    check_eq("reset_ovf", overflow, 0);
    prod_valid = 1'b1; prod_in = 8'd5;
    repeat (3) @(negedge clk);
    prod_valid = 1'b0;
    check_idle("idle_valid", 0);

    q = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_dot("seq", q, 0, 0);
    q = '{-56, -56, -56, -56, 49, 49, 49, 49};
    run_dot("mix", q, 0, 1);
    q = '{127, 127, 127, 127, 127, 127, 127, 127};
    run_dot("satpos", q, 0, 0);
    q = '{-128, -128, -128, -128, -128, -128, -128, -128};
    run_dot("satneg", q, 0, 0);
    q = '{127, 127, 127, 127, -128, -128, -128, -128};
    run_dot("nosat", q, 0, 0);
    q = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_dot("backpress", q, 1, 5);
    q = '{127, 127, 127, 127, 127, -128, -128, -128};
    run_dot("offrail", q, 0, 0);

    // Reset in the middle of an accumulation discards the partial sum.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prod_valid = 1'b1; prod_in = 8'd10;
      @(negedge clk);
    end
    prod_valid = 1'b0;
    check_eq("midrst_partial", acc_s(), 30);
    do_reset(1);
    check_idle("midrst", 0);
    check_eq("midrst_ovf", overflow, 0);
    q = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_dot("after_rst", q, 0, 0);

    // Randomized dot products with gaps and hold stalls.
    for (int t = 0; t < 25; t++) begin
      q = {};
      for (int i = 0; i < int'(LEN); i++) begin
        q.push_back(int'($urandom_range(255)) - 128);
      end
      run_dot($sformatf("rand%0d", t), q, 2, int'($urandom_range(3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
